rf_wb_sched: RTL
================

Name: rf_wb_sched

Overview:
- Write-back scheduler for the 32x32 integer register file.
- Shares the regfile's single write port between two producers:
  - ALU write-back (port A)
  - LSU load write-back (port L)
- Arbitrates round-robin with valid/ready handshakes and registers the winning write into a one-entry write stage that drives the regfile.
- Holds a 32-entry pending-write scoreboard. Decode uses it to stall RAW and WAW hazards on rs1/rs2/rd.

Parameters:
- DATA_W, 32, write-data width.
- IDX_W, 5, register index width (2**IDX_W registers).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- i_iss_valid  input  1  decode issuing an instruction that writes rd.
- i_iss_rdidx  input  IDX_W  destination of the issuing instruction.
- o_iss_ready  output  1  issue accepted (rd not pending).
- i_rs1_idx  input  IDX_W  decode source 1 index.
- i_rs2_idx  input  IDX_W  decode source 2 index.
- o_rs1_busy  output  1  rs1 has a pending write.
- o_rs2_busy  output  1  rs2 has a pending write.
- i_a_valid  input  1  ALU write-back request.
- i_a_rdidx  input  IDX_W  ALU destination.
- i_a_wdat  input  DATA_W  ALU result.
- o_a_ready  output  1  ALU request granted.
- i_l_valid  input  1  LSU write-back request.
- i_l_rdidx  input  IDX_W  LSU destination.
- i_l_wdat  input  DATA_W  load data.
- o_l_ready  output  1  LSU request granted.
- o_rf_wen  output  1  regfile write enable.
- o_rf_rdidx  output  IDX_W  regfile write index.
- o_rf_wdat  output  DATA_W  regfile write data.

Behaviour:

Reset (asynchronous, rst=1):
- Scoreboard cleared to all zero.
- Round-robin pointer set to A.
- o_rf_wen=0, o_rf_rdidx=0, o_rf_wdat=0.
- Outputs are valid immediately on assertion.
- An in-flight write stage is discarded. A mid-operation reset therefore loses the pending write and its scoreboard bit.

Scoreboard (`busy[2**IDX_W-1:0]`):
- o_iss_ready = ~busy[i_iss_rdidx] | (i_iss_rdidx==0).
  - This is combinational and independent of i_iss_valid.
- Issue handshake: i_iss_valid & o_iss_ready, with rdidx != 0, sets busy[rdidx] at the next edge.
  - Issues with rd=0 are accepted and never set busy.
- o_rs1_busy = busy[i_rs1_idx]; o_rs2_busy = busy[i_rs2_idx].
  - Both are combinational.
  - busy[0] is constantly 0.
- Clear: busy[o_rf_rdidx] is cleared at the edge ending a cycle in which o_rf_wen=1.
  - The register is therefore visible as not-busy in the cycle after the regfile write. No bypass is provided.
- Set and clear of different indices in the same cycle: both take effect.
- Set and clear of the same index cannot coincide, because issue of a busy rd is refused. If it did coincide, set wins.

Arbitration (combinational grant, registered write):
- Grant goes to one of the valid requesters.
- Only one valid: that requester wins.
- Both valid: the one not granted most recently wins.
  - The pointer updates only on an actual grant, so with both valid the grant alternates A, L, A, L…
- o_a_ready / o_l_ready are asserted only for the granted port, and only when that port's valid is high.
  - Ready never depends on its own port's data.
- The write stage never back-pressures. One grant per cycle is always possible.

Write stage:
- Latency 1 cycle: a grant in cycle N produces o_rf_wen=1 in cycle N+1, with that request's rdidx/wdat.
- With no grant, o_rf_wen=0 next cycle and o_rf_rdidx/o_rf_wdat hold their previous values.
- A granted write to rd=0 is consumed (ready=1) but produces o_rf_wen=0.
- A write-back to a non-busy rd is a protocol violation. It is written regardless, and the clear is a no-op.

Decomposition:
- Shared package: the IDX_W/DATA_W defaults, the x0 index constant, and the port-select encoding (SEL_A=0, SEL_L=1) used by the round-robin pointer.
- One natural sub-module, `rf_scoreboard`: the busy vector with set/clear/two read ports and o_iss_ready.
- The arbiter and the write stage stay in the top module.

Test Plan:
- Reset mid-operation: issue rd=5, assert rst for 1 cycle → o_rs1_busy with rs1=5 reads 0, o_rf_wen=0, o_iss_ready=1 for rd=5.
- RAW path: issue rd=7, then A writes rd=7/0xDEADBEEF one cycle later.
  - busy stays 1 through the o_rf_wen=1 cycle (rdidx=7, wdat=0xDEADBEEF), then o_rs2_busy(rs2=7)=0 the next cycle.
- WAW refusal: issue rd=3 accepted; a second issue of rd=3 → o_iss_ready=0 until the cycle after the commit of rd=3.
- Contention: A and L valid continuously for 4 cycles (A→rd1..., L→rd2...) → grants A, L, A, L; o_rf_wen=1 each cycle from cycle 2 with the matching data.
- x0 handling: issue rd=0 → o_iss_ready=1, busy unchanged; L writes rd=0 → o_l_ready=1, next-cycle o_rf_wen=0.
- Concurrent set/clear: commit of rd=4 in the same cycle as issue of rd=9 → next cycle busy[4]=0 and busy[9]=1.

Source files
------------

// File: rtl/rf_wb_sched_pkg.sv
// Shared definitions for the register-file write-back scheduler:
// width defaults, the x0 index and the round-robin port encoding.
package rf_wb_sched_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned IDX_W_DEF  = 5;

  // Register x0 is hardwired to zero, so it is never tracked or written.
  localparam int unsigned X0_IDX = 0;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_L = 1'b1
  } sel_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register,
// set on issue, cleared on regfile commit, read by decode for hazard stalls.
module rf_scoreboard
  import rf_wb_sched_pkg::*;
#(
  parameter int unsigned IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid_i,
  input  logic [IDX_W-1:0] iss_rdidx_i,
  output logic             iss_ready_o,
  input  logic [IDX_W-1:0] rs1_idx_i,
  input  logic [IDX_W-1:0] rs2_idx_i,
  output logic             rs1_busy_o,
  output logic             rs2_busy_o,
  input  logic             clr_en_i,
  input  logic [IDX_W-1:0] clr_idx_i
);

  localparam int unsigned NREG = 2 ** IDX_W;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            iss_is_x0;
  logic            set_en;

  assign iss_is_x0   = (iss_rdidx_i == IDX_W'(X0_IDX));
  assign iss_ready_o = ~busy_q[iss_rdidx_i] | iss_is_x0;
  assign set_en      = iss_valid_i & iss_ready_o & ~iss_is_x0;

  assign rs1_busy_o  = busy_q[rs1_idx_i];
  assign rs2_busy_o  = busy_q[rs2_idx_i];

  // Clear is applied before set so that a same-index collision leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) begin
      busy_d[clr_idx_i] = 1'b0;
    end
    if (set_en) begin
      busy_d[iss_rdidx_i] = 1'b1;
    end
    busy_d[X0_IDX] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/rf_wb_sched.sv
// Write-back scheduler: round-robin arbitration of ALU and LSU results onto
// the single regfile write port, plus the decode hazard scoreboard.
module rf_wb_sched
  import rf_wb_sched_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IDX_W  = IDX_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_iss_valid,
  input  logic [IDX_W-1:0]  i_iss_rdidx,
  output logic              o_iss_ready,
  input  logic [IDX_W-1:0]  i_rs1_idx,
  input  logic [IDX_W-1:0]  i_rs2_idx,
  output logic              o_rs1_busy,
  output logic              o_rs2_busy,
  input  logic              i_a_valid,
  input  logic [IDX_W-1:0]  i_a_rdidx,
  input  logic [DATA_W-1:0] i_a_wdat,
  output logic              o_a_ready,
  input  logic              i_l_valid,
  input  logic [IDX_W-1:0]  i_l_rdidx,
  input  logic [DATA_W-1:0] i_l_wdat,
  output logic              o_l_ready,
  output logic              o_rf_wen,
  output logic [IDX_W-1:0]  o_rf_rdidx,
  output logic [DATA_W-1:0] o_rf_wdat
);

  sel_e              ptr_q;
  sel_e              ptr_d;
  logic              wen_q;
  logic              wen_d;
  logic [IDX_W-1:0]  rdidx_q;
  logic [IDX_W-1:0]  rdidx_d;
  logic [DATA_W-1:0] wdat_q;
  logic [DATA_W-1:0] wdat_d;
  logic              grant_a;
  logic              grant_l;

  // The pointer names the port that wins a tie; it flips only on a real grant.
  assign grant_a = i_a_valid & (~i_l_valid | (ptr_q == SEL_A));
  assign grant_l = i_l_valid & (~i_a_valid | (ptr_q == SEL_L));

  assign o_a_ready  = grant_a;
  assign o_l_ready  = grant_l;
  assign o_rf_wen   = wen_q;
  assign o_rf_rdidx = rdidx_q;
  assign o_rf_wdat  = wdat_q;

  always_comb begin
    ptr_d   = ptr_q;
    wen_d   = 1'b0;
    rdidx_d = rdidx_q;
    wdat_d  = wdat_q;
    if (grant_a) begin
      ptr_d   = SEL_L;
      wen_d   = (i_a_rdidx != IDX_W'(X0_IDX));
      rdidx_d = i_a_rdidx;
      wdat_d  = i_a_wdat;
    end else if (grant_l) begin
      ptr_d   = SEL_A;
      wen_d   = (i_l_rdidx != IDX_W'(X0_IDX));
      rdidx_d = i_l_rdidx;
      wdat_d  = i_l_wdat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= SEL_A;
      wen_q   <= 1'b0;
      rdidx_q <= '0;
      wdat_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      wen_q   <= wen_d;
      rdidx_q <= rdidx_d;
      wdat_q  <= wdat_d;
    end
  end

  rf_scoreboard #(
    .IDX_W(IDX_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .iss_valid_i (i_iss_valid),
    .iss_rdidx_i (i_iss_rdidx),
    .iss_ready_o (o_iss_ready),
    .rs1_idx_i   (i_rs1_idx),
    .rs2_idx_i   (i_rs2_idx),
    .rs1_busy_o  (o_rs1_busy),
    .rs2_busy_o  (o_rs2_busy),
    .clr_en_i    (wen_q),
    .clr_idx_i   (rdidx_q)
  );

endmodule
